// File: rtl/uart_pkg.sv
// Shared definitions for the telemetry framer: FSM states, default header
// byte and the frame length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    ACK  = 3'd2,
    TXW  = 3'd3,
    GAPW = 3'd4,
    NEXT = 3'd5
  } state_e;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  // Header + payload bytes + optional checksum byte.
  function automatic int frame_len(input int nch, input int dw, input int csum_en);
    return 1 + (nch * dw) / 8 + csum_en;
  endfunction

endpackage

// File: rtl/uart_byte_sel.sv
// Combinational byte picker: index 0 is the header, then the snapshot
// channels MSB-first starting with channel 0, then the checksum byte.
module uart_byte_sel
  import uart_pkg::*;
#(
  parameter int         NCH     = 3,
  parameter int         DW      = 32,
  parameter logic [7:0] HDR     = HDR_DEFAULT,
  parameter int         CSUM_EN = 1,
  parameter int         IDX_W   = 4
) (
  input  logic [IDX_W-1:0]  idx,
  input  logic [NCH*DW-1:0] snapshot,
  input  logic [7:0]        csum,
  output logic [7:0]        byte_o
);

  localparam int NPB = (NCH * DW) / 8;
  localparam int BPC = DW / 8;

  // Header by default; payload position p maps to channel p/BPC, byte p%BPC from the top.
  always_comb begin
    byte_o = HDR;
    for (int p = 0; p < NPB; p++) begin
      if (idx == IDX_W'(p + 1)) begin
        byte_o = snapshot[(p / BPC) * DW + (BPC - 1 - (p % BPC)) * 8 +: 8];
      end
    end
    if ((CSUM_EN != 0) && (idx == IDX_W'(NPB + 1))) begin
      byte_o = csum;
    end
  end

endmodule

// File: rtl/uart_coord_framer.sv
// Telemetry framer: on a rising edge of valid, freezes NCH channels and
// hands one framed packet (header, payload, optional checksum) to a byte
// UART, pacing every byte on the transmitter's tx_idle handshake.
module uart_coord_framer
  import uart_pkg::*;
#(
  parameter int         NCH     = 3,
  parameter int         DW      = 32,
  parameter logic [7:0] HDR     = HDR_DEFAULT,
  parameter int         CSUM_EN = 1,
  parameter int         GAP     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              valid,
  input  logic [NCH*DW-1:0] data_in,
  input  logic              tx_idle,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  output logic              busy,
  output logic              done,
  output logic              dropped
);

  localparam int                L        = frame_len(NCH, DW, CSUM_EN);
  localparam int                NPB      = (NCH * DW) / 8;
  localparam int                IDX_W    = $clog2(L);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(L - 1);
  localparam logic [IDX_W-1:0]  IDX_PAY  = IDX_W'(NPB);
  localparam logic [7:0]        GAP_LAST = 8'((GAP > 0) ? (GAP - 1) : 0);

  if ((DW % 8) != 0 || DW < 8 || DW > 32 || NCH < 1 || NCH > 8 ||
      GAP < 0 || GAP > 255 || CSUM_EN < 0 || CSUM_EN > 1) begin : g_bad_param
    $error("uart_coord_framer: illegal parameter set");
  end

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NCH*DW-1:0]   snap_q, snap_d;
  logic [7:0]          csum_q, csum_d;
  logic [7:0]          gap_q, gap_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_wr_q, tx_wr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dropped_q, dropped_d;
  logic                valid_q, valid_d;
  logic [7:0]          sel_byte;
  logic                start;

  uart_byte_sel #(
    .NCH     (NCH),
    .DW      (DW),
    .HDR     (HDR),
    .CSUM_EN (CSUM_EN),
    .IDX_W   (IDX_W)
  ) u_byte_sel (
    .idx      (idx_q),
    .snapshot (snap_q),
    .csum     (csum_q),
    .byte_o   (sel_byte)
  );

  assign start = valid & ~valid_q;

  // Next-state logic: clr dominates everything, including a same-cycle start.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    csum_d    = csum_q;
    gap_d     = gap_q;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dropped_d = 1'b0;
    valid_d   = valid;

    if (clr) begin
      state_d = IDLE;
      idx_d   = '0;
      snap_d  = '0;
      csum_d  = '0;
      gap_d   = '0;
      busy_d  = 1'b0;
    end else begin
      if (start && busy_q) begin
        dropped_d = 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            snap_d  = data_in;
            idx_d   = '0;
            csum_d  = '0;
            busy_d  = 1'b1;
            state_d = ARM;
          end
        end
        ARM: begin
          if (tx_idle) begin
            tx_data_d = sel_byte;
            tx_wr_d   = 1'b1;
            if (idx_q != '0 && idx_q <= IDX_PAY) begin
              csum_d = csum_q + sel_byte;
            end
            state_d = ACK;
          end
        end
        ACK: begin
          if (!tx_idle) begin
            state_d = TXW;
          end
        end
        TXW: begin
          if (tx_idle) begin
            gap_d   = '0;
            state_d = (GAP > 0) ? GAPW : NEXT;
          end
        end
        GAPW: begin
          if (gap_q == GAP_LAST) begin
            state_d = NEXT;
          end else begin
            gap_d = gap_q + 8'd1;
          end
        end
        NEXT: begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ARM;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; asynchronous reset returns to a clean idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      snap_q    <= '0;
      csum_q    <= '0;
      gap_q     <= '0;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      csum_q    <= csum_d;
      gap_q     <= gap_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
      valid_q   <= valid_d;
    end
  end

  assign tx_data = tx_data_q;
  assign tx_wr   = tx_wr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_uart_coord_framer.sv
// Bench for uart_coord_framer: two instances (3x32 with checksum, 1x16 with
// gap), a behavioural uarttx model each, and scoreboards fed by a
// frame-building reference model.
module tb_uart_coord_framer;

  logic        clk = 1'b0;
  logic        rst_n, clr, valid, tx_idle, idle_block;
  logic [95:0] data_in;
  logic [7:0]  tx_data;
  logic        tx_wr, busy, done, dropped;

  logic        valid_b, tx_idle_b;
  logic [15:0] data_b;
  logic [7:0]  tx_data_b;
  logic        tx_wr_b, busy_b, done_b, dropped_b;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, done_cnt = 0, drop_cnt = 0;
  int wr_b_cnt = 0, done_b_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b_q[$];

  always #5 clk = ~clk;

  uart_coord_framer dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .valid(valid), .data_in(data_in),
    .tx_idle(tx_idle), .tx_data(tx_data), .tx_wr(tx_wr), .busy(busy),
    .done(done), .dropped(dropped)
  );

  uart_coord_framer #(.NCH(1), .DW(16), .CSUM_EN(0), .GAP(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .valid(valid_b), .data_in(data_b),
    .tx_idle(tx_idle_b), .tx_data(tx_data_b), .tx_wr(tx_wr_b), .busy(busy_b),
    .done(done_b), .dropped(dropped_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference model: header, each channel's bytes most significant first, then mod-256 payload sum.
  task automatic push_frame(input logic [95:0] d);
    int sum = 0;
    exp_q.push_back(8'hA5);
    for (int ch = 0; ch < 3; ch++) begin
      logic [31:0] w = d[ch*32 +: 32];
      for (int k = 3; k >= 0; k--) begin
        int bv = (w >> (8 * k)) & 255;
        exp_q.push_back(8'(bv));
        sum = (sum + bv) % 256;
      end
    end
    exp_q.push_back(8'(sum));
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_wr(input int target, input string nm);
    int n = 0;
    while (wr_cnt < target && n < 3000) begin step(); n++; end
    if (wr_cnt < target) chk(nm, 32'(wr_cnt), 32'(target));
  endtask

  task automatic wait_done(input int target, input string nm);
    int n = 0;
    while (done_cnt < target && n < 3000) begin step(); n++; end
    if (done_cnt < target) chk(nm, 32'(done_cnt), 32'(target));
  endtask

  // uarttx model A: goes busy the cycle after a write, for a random line time.
  initial begin
    int cnt = 0;
    tx_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && tx_wr) cnt = $urandom_range(3, 12);
      else if (cnt > 0) cnt--;
      tx_idle = (cnt == 0) && !idle_block;
    end
  end

  // uarttx model B: fixed line time.
  initial begin
    int cnt = 0;
    tx_idle_b = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && tx_wr_b) cnt = 6;
      else if (cnt > 0) cnt--;
      tx_idle_b = (cnt == 0);
    end
  end

  // Monitor A: pops the scoreboard on each write strobe, counts done/dropped pulses.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && tx_wr) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx_wr actual=%0h required=none", tx_data);
        end else begin
          chk("tx_byte_a", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (rst_n && done) done_cnt++;
      if (rst_n && dropped) drop_cnt++;
    end
  end

  // Monitor B: byte scoreboard plus minimum spacing from tx_idle rising to the next write.
  initial begin
    int cyc = 0, t_rise = 0;
    logic prev_idle = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (tx_idle_b && !prev_idle) t_rise = cyc;
      prev_idle = tx_idle_b;
      if (rst_n && tx_wr_b) begin
        if (wr_b_cnt > 0) chk("gap_b_ge10", 32'(cyc - t_rise >= 10), 32'd1);
        wr_b_cnt++;
        if (exp_b_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx_wr_b actual=%0h required=none", tx_data_b);
        end else begin
          chk("tx_byte_b", {24'd0, tx_data_b}, {24'd0, exp_b_q.pop_front()});
        end
      end
      if (rst_n && done_b) done_b_cnt++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bw, bd, bdr, n;
    logic [95:0] d;
    logic [7:0] t1[14] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                           8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'h2E};
    rst_n = 1'b0; clr = 1'b0; valid = 1'b0; idle_block = 1'b0;
    data_in = '0; valid_b = 1'b0; data_b = '0;
    repeat (3) step();
    chk("rst_tx_wr", {31'd0, tx_wr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dropped", {31'd0, dropped}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    rst_n = 1'b1;
    repeat (3) step();

    // Known frame with literal expected bytes and start latency.
    for (int i = 0; i < 14; i++) exp_q.push_back(t1[i]);
    data_in = {32'h99AABBCC, 32'h55667788, 32'h11223344};
    bw = wr_cnt; bd = done_cnt;
    valid = 1'b1;
    n = 0;
    do begin step(); n++; end while (!tx_wr && n < 20);
    chk("start_latency", 32'(n), 32'd2);
    wait_done(bd + 1, "t1_done_timeout");
    step();
    chk("t1_wr_count", 32'(wr_cnt - bw), 32'd14);
    chk("t1_done_once", 32'(done_cnt - bd), 32'd1);
    chk("t1_busy_low", {31'd0, busy}, 32'd0);
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    valid = 1'b0;
    step();

    // Valid held high: exactly one frame.
    d = {$urandom, $urandom, $urandom};
    data_in = d; push_frame(d);
    bw = wr_cnt; bd = done_cnt;
    valid = 1'b1;
    repeat (20000) step();
    valid = 1'b0;
    step();
    chk("t2_wr_count", 32'(wr_cnt - bw), 32'd14);
    chk("t2_done_once", 32'(done_cnt - bd), 32'd1);

    // Second edge mid-frame is dropped; data_in changes are ignored.
    d = {$urandom, $urandom, $urandom};
    data_in = d; push_frame(d);
    bw = wr_cnt; bd = done_cnt; bdr = drop_cnt;
    valid = 1'b1; step();
    wait_wr(bw + 5, "t3_wr5_timeout");
    valid = 1'b0; data_in = {$urandom, $urandom, $urandom}; step();
    valid = 1'b1; step();
    valid = 1'b0; step();
    chk("t3_dropped_once", 32'(drop_cnt - bdr), 32'd1);
    wait_done(bd + 1, "t3_done_timeout");
    repeat (200) step();
    chk("t3_wr_count", 32'(wr_cnt - bw), 32'd14);
    chk("t3_done_once", 32'(done_cnt - bd), 32'd1);

    // clr after the third write: abort, no done, restart from the header.
    d = {$urandom, $urandom, $urandom};
    data_in = d; push_frame(d);
    bw = wr_cnt; bd = done_cnt;
    valid = 1'b1; step(); valid = 1'b0;
    wait_wr(bw + 3, "t4_wr3_timeout");
    clr = 1'b1; exp_q.delete();
    step();
    clr = 1'b0;
    chk("t4_busy_after_clr", {31'd0, busy}, 32'd0);
    chk("t4_tx_wr_after_clr", {31'd0, tx_wr}, 32'd0);
    repeat (300) step();
    chk("t4_no_more_wr", 32'(wr_cnt - bw), 32'd3);
    chk("t4_no_done", 32'(done_cnt - bd), 32'd0);
    d = {$urandom, $urandom, $urandom};
    data_in = d; push_frame(d);
    valid = 1'b1; step(); valid = 1'b0;
    wait_done(bd + 1, "t4_restart_timeout");
    chk("t4_restart_wr", 32'(wr_cnt - bw), 32'd17);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // GAP instance: A5 BE EF with spacing after each byte.
    exp_b_q.push_back(8'hA5); exp_b_q.push_back(8'hBE); exp_b_q.push_back(8'hEF);
    data_b = 16'hBEEF;
    valid_b = 1'b1; step(); valid_b = 1'b0;
    n = 0;
    while (done_b_cnt < 1 && n < 3000) begin step(); n++; end
    chk("t5_done_b", 32'(done_b_cnt), 32'd1);
    chk("t5_wr_b_count", 32'(wr_b_cnt), 32'd3);
    chk("t5_busy_b_low", {31'd0, busy_b}, 32'd0);

    // Reset mid-frame, then a start that stalls while tx_idle is low.
    d = {$urandom, $urandom, $urandom};
    data_in = d; push_frame(d);
    bw = wr_cnt;
    valid = 1'b1; step(); valid = 1'b0;
    wait_wr(bw + 4, "t6_wr4_timeout");
    rst_n = 1'b0; exp_q.delete();
    #1;
    chk("t6_rst_tx_wr", {31'd0, tx_wr}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_done", {31'd0, done}, 32'd0);
    chk("t6_rst_dropped", {31'd0, dropped}, 32'd0);
    chk("t6_rst_tx_data", {24'd0, tx_data}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    repeat (100) step();
    chk("t6_no_resume", 32'(wr_cnt - bw), 32'd4);
    idle_block = 1'b1;
    repeat (3) step();
    d = {$urandom, $urandom, $urandom};
    data_in = d; push_frame(d);
    bw = wr_cnt; bd = done_cnt;
    valid = 1'b1; step(); valid = 1'b0;
    repeat (50) step();
    chk("t6_stall_no_wr", 32'(wr_cnt - bw), 32'd0);
    chk("t6_stall_busy", {31'd0, busy}, 32'd1);
    idle_block = 1'b0;
    wait_done(bd + 1, "t6_done_timeout");
    chk("t6_wr_count", 32'(wr_cnt - bw), 32'd14);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
